// File: rtl/rodada_colunas_seq.sv
// AES round tail: ShiftRows on accept, then one MixColumns+AddRoundKey column
// per cycle, with valid/ready handshakes on both sides.

module rodada_mix_linha #(
  parameter int ROW = 0
) (
  input  logic [3:0][7:0] col,
  input  logic            bypass,
  output logic [7:0]      b
);
  localparam int R1 = (ROW + 1) % 4;
  localparam int R2 = (ROW + 2) % 4;
  localparam int R3 = (ROW + 3) % 4;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Every MixColumns row is 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3]
  logic [7:0] mix;
  always_comb begin
    mix = xtime(col[ROW]) ^ xtime(col[R1]) ^ col[R1] ^ col[R2] ^ col[R3];
    b   = bypass ? col[ROW] : mix;
  end
endmodule

module rodada_colunas_seq (
  input  logic         clock,
  input  logic         reset,
  input  logic [127:0] entrada,
  input  logic [127:0] chave,
  input  logic         ultima,
  input  logic         entrada_valida,
  output logic         pronto,
  output logic [127:0] saida,
  output logic         saida_valida,
  input  logic         saida_pronta
);
  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    COLUNA    = 2'd1,
    CONCLUIDO = 2'd2
  } estado_t;

  estado_t        estado_q, estado_d;
  logic [1:0]     col_q, col_d;
  logic [127:0]   dados_q, dados_d;
  logic [127:0]   chave_q, chave_d;
  logic           ultima_q, ultima_d;
  logic [127:0]   saida_q, saida_d;
  logic           pronto_q, pronto_d;
  logic           valida_q, valida_d;

  logic [3:0][7:0] col_a;
  logic [3:0][7:0] col_b;
  logic [31:0]     col_k;

  function automatic logic [127:0] shift_rows(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[8*(4*c+r) +: 8] = x[8*(4*((c+r)%4)+r) +: 8];
    return y;
  endfunction

  assign col_a = dados_q[32*col_q +: 32];
  assign col_k = chave_q[32*col_q +: 32];

  for (genvar r = 0; r < 4; r++) begin : g_linha
    rodada_mix_linha #(.ROW(r)) u_linha (
      .col    (col_a),
      .bypass (ultima_q),
      .b      (col_b[r])
    );
  end

  always_comb begin
    estado_d = estado_q;
    col_d    = col_q;
    dados_d  = dados_q;
    chave_d  = chave_q;
    ultima_d = ultima_q;
    saida_d  = saida_q;
    case (estado_q)
      OCIOSO: begin
        if (entrada_valida) begin
          dados_d  = shift_rows(entrada);
          chave_d  = chave;
          ultima_d = ultima;
          col_d    = 2'd0;
          estado_d = COLUNA;
        end
      end
      COLUNA: begin
        saida_d[32*col_q +: 32] = col_b ^ col_k;
        if (col_q == 2'd3) estado_d = CONCLUIDO;
        else               col_d    = col_q + 2'd1;
      end
      CONCLUIDO: begin
        if (saida_pronta) estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
    // Handshake outputs are registered copies of the next-state decode
    pronto_d = (estado_d == OCIOSO);
    valida_d = (estado_d == CONCLUIDO);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
      col_q    <= 2'd0;
      dados_q  <= '0;
      chave_q  <= '0;
      ultima_q <= 1'b0;
      saida_q  <= '0;
      pronto_q <= 1'b1;
      valida_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      col_q    <= col_d;
      dados_q  <= dados_d;
      chave_q  <= chave_d;
      ultima_q <= ultima_d;
      saida_q  <= saida_d;
      pronto_q <= pronto_d;
      valida_q <= valida_d;
    end
  end

  assign pronto       = pronto_q;
  assign saida_valida = valida_q;
  assign saida        = saida_q;
endmodule

// File: tb/tb_rodada_colunas_seq.sv
// Randomized bench for rodada_colunas_seq against a byte-matrix AES round model.

module tb_rodada_colunas_seq;
  logic         clock = 1'b0;
  logic         reset;
  logic [127:0] entrada, chave;
  logic         ultima, entrada_valida, saida_pronta;
  logic         pronto, saida_valida;
  logic [127:0] saida;

  rodada_colunas_seq dut (
    .clock(clock), .reset(reset), .entrada(entrada), .chave(chave),
    .ultima(ultima), .entrada_valida(entrada_valida), .pronto(pronto),
    .saida(saida), .saida_valida(saida_valida), .saida_pronta(saida_pronta)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input int k);
    logic [7:0] r, p;
    r = 8'h00; p = a;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) r ^= p;
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [127:0] round_ref(input logic [127:0] e, input logic [127:0] k,
                                             input logic u);
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [7:0] v;
    logic [127:0] o;
    int coef [4];
    coef = '{2, 3, 1, 1};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = e[8*(4*c+r) +: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r][c] = s[r][(c+r)%4];
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        if (u) v = t[r][c];
        else begin
          v = 8'h00;
          for (int j = 0; j < 4; j++) v ^= gmul(t[j][c], coef[(j-r+4)%4]);
        end
        o[8*(4*c+r) +: 8] = v ^ k[8*(4*c+r) +: 8];
      end
    return o;
  endfunction

  // Cycle model: phase 0 idle, 1..4 column work, 5 result presented
  int           m_phase = 0;
  logic [127:0] m_saida = '0, m_pend = '0;
  logic         m_on = 1'b0;
  int           cyc = 0, acc_cnt = 0, acc_cyc = 0;
  int           acc_q [$];

  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      m_phase = 0; m_saida = '0; m_on = 1'b1;
    end else begin
      case (m_phase)
        0: if (entrada_valida) begin
             m_pend = round_ref(entrada, chave, ultima);
             m_phase = 1; acc_cnt++; acc_cyc = cyc; acc_q.push_back(cyc);
           end
        1, 2, 3: m_phase++;
        4: begin m_phase = 5; m_saida = m_pend; end
        5: if (saida_pronta) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clock) begin
    if (m_on) begin
      chk("pronto", pronto, m_phase == 0);
      chk("saida_valida", saida_valida, m_phase == 5);
      if (m_phase == 0 || m_phase == 1 || m_phase == 5) chk("saida", saida, m_saida);
    end
  end

  task automatic send(input logic [127:0] e, input logic [127:0] k, input logic u);
    int c0;
    bit got;
    got = 1'b0;
    @(negedge clock);
    entrada = e; chave = k; ultima = u; entrada_valida = 1'b1; c0 = acc_cnt;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clock); #1;
      if (acc_cnt != c0) got = 1'b1;
    end
    entrada_valida = 1'b0;
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout got=none exp=accept");
    end
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (saida_valida === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL valid_timeout got=0 exp=1");
    end
  endtask

  task automatic release_out();
    saida_pronta = 1'b1;
    @(negedge clock);
    saida_pronta = 1'b0;
    chk("release_pronto", pronto, 1'b1);
  endtask

  task automatic run_lit(input string nm, input logic [127:0] e, input logic [127:0] k,
                         input logic u, input logic [127:0] exp);
    chk({nm, "_model"}, round_ref(e, k, u), exp);
    send(e, k, u);
    wait_valid();
    chk({nm, "_latency"}, cyc - acc_cyc, 4);
    chk(nm, saida, exp);
    release_out();
  endtask

  localparam logic [127:0] E_MIX = 128'h455313db455313db455313db455313db;
  localparam logic [127:0] E_SEQ = 128'h0f0e0d0c0b0a09080706050403020100;

  initial begin
    logic [127:0] held, e, k;
    entrada = '0; chave = '0; ultima = 1'b0; entrada_valida = 1'b0;
    saida_pronta = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("reset_pronto", pronto, 1'b1);
    chk("reset_valida", saida_valida, 1'b0);
    chk("reset_saida", saida, '0);

    run_lit("mixcolumns", E_MIX, '0, 1'b0, 128'hbca14d8ebca14d8ebca14d8ebca14d8e);
    run_lit("shiftrows", E_SEQ, '0, 1'b1, 128'h0b06010c07020d08030e09040f0a0500);
    run_lit("addroundkey", E_MIX, {128{1'b1}}, 1'b0, 128'h435eb271435eb271435eb271435eb271);

    // Backpressure with ignored input pulses
    e = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    send(e, k, 1'b0);
    wait_valid();
    held = saida;
    chk("bp_result", held, round_ref(e, k, 1'b0));
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("bp_saida", saida, held);
      chk("bp_valida", saida_valida, 1'b1);
      chk("bp_pronto", pronto, 1'b0);
      entrada = {$urandom, $urandom, $urandom, $urandom};
      entrada_valida = (i % 2 == 0);
    end
    entrada_valida = 1'b0;
    @(negedge clock);
    release_out();

    // Reset landing on the col=2 edge
    send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    @(posedge clock); @(posedge clock);
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    chk("midreset_pronto", pronto, 1'b1);
    chk("midreset_valida", saida_valida, 1'b0);
    chk("midreset_saida", saida, '0);
    e = {$urandom, $urandom, $urandom, $urandom};
    send(e, '0, 1'b1);
    wait_valid();
    chk("postreset_result", saida, round_ref(e, '0, 1'b1));
    release_out();

    // Back-to-back with downstream always ready
    acc_q.delete();
    saida_pronta = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      entrada = {$urandom, $urandom, $urandom, $urandom};
      chave = {$urandom, $urandom, $urandom, $urandom};
      ultima = $urandom_range(0, 1);
      entrada_valida = 1'b1;
    end
    @(negedge clock);
    entrada_valida = 1'b0;
    repeat (8) @(negedge clock);
    chk("b2b_accepts", acc_q.size(), 3);
    if (acc_q.size() >= 2) chk("b2b_spacing", acc_q[1] - acc_q[0], 6);

    // Random traffic, occasional reset
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      reset = ($urandom_range(0, 59) == 0);
      entrada = {$urandom, $urandom, $urandom, $urandom};
      chave = {$urandom, $urandom, $urandom, $urandom};
      ultima = $urandom_range(0, 1);
      entrada_valida = $urandom_range(0, 1);
      saida_pronta = $urandom_range(0, 1);
    end
    @(negedge clock);
    reset = 1'b0; entrada_valida = 1'b0; saida_pronta = 1'b1;
    repeat (10) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
